// File: rtl/vec_mul_pkg.sv
// Shared defaults and FSM state type for the matrix-vector row sequencer.
package vec_mul_pkg;

    localparam int DEF_DATA_BW        = 8;
    localparam int DEF_PARTIAL_MUL_BW = 16;
    localparam int DEF_PARTIAL_SUM_BW = 20;
    localparam int DEF_MATRIX_SIZE    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VEC,
        ROWS,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/adder_tree_8.sv
// Combinational three-level adder tree over eight signed terms packed in a flat bus.
module adder_tree_8 #(
    parameter int IN_BW  = 16,
    parameter int OUT_BW = IN_BW + 3
) (
    input  logic        [8*IN_BW-1:0] in_flat,
    output logic signed [OUT_BW-1:0]  sum
);

    logic signed [OUT_BW-1:0] lvl0 [8];
    logic signed [OUT_BW-1:0] lvl1 [4];
    logic signed [OUT_BW-1:0] lvl2 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl0[i] = OUT_BW'($signed(in_flat[i*IN_BW +: IN_BW]));
        end
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
    end

    assign sum = lvl2[0] + lvl2[1];

endmodule

// File: rtl/mvm_row_sequencer.sv
// Streams matrix rows against a latched vector, emitting one registered dot product per row.
module mvm_row_sequencer
    import vec_mul_pkg::*;
#(
    parameter int DATA_BW        = DEF_DATA_BW,
    parameter int PARTIAL_MUL_BW = DEF_PARTIAL_MUL_BW,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]    vec_in_flat,
    input  logic                              vec_valid,
    output logic                              vec_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]    row_in_flat,
    input  logic                              row_valid,
    output logic                              row_ready,
    output logic signed [PARTIAL_SUM_BW-1:0]  out_sum,
    output logic [2:0]                        out_row_idx,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done
);

    localparam int VEC_W  = DATA_BW * MATRIX_SIZE;
    localparam int ACC_BW = PARTIAL_MUL_BW + 3;

    seq_state_t                               state;
    logic [VEC_W-1:0]                         vec_q;
    logic [2:0]                               row_cnt;
    logic [MATRIX_SIZE*PARTIAL_MUL_BW-1:0]    prod_p0;
    logic signed [ACC_BW-1:0]                 acc_p0;
    logic signed [PARTIAL_SUM_BW-1:0]         sum_p1;
    logic [2:0]                               idx_p1;
    logic                                     vld_p1;
    logic                                     done_q;
    logic                                     vec_hs;
    logic                                     row_hs;

    // Exact below 19 bits of headroom is impossible, so narrower outputs wrap modulo 2^PARTIAL_SUM_BW.
    function automatic logic signed [PARTIAL_SUM_BW-1:0] wrap_sum(input logic signed [ACC_BW-1:0] s);
        return PARTIAL_SUM_BW'(s);
    endfunction

    assign vec_ready = (state == WAIT_VEC);
    assign row_ready = (state == ROWS) && (!vld_p1 || out_ready);
    assign vec_hs    = vec_valid && vec_ready;
    assign row_hs    = row_valid && row_ready;
    assign busy      = (state != IDLE);

    // Stage p0: element products of the presented row and the latched vector, then the tree.
    always_comb begin
        prod_p0 = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            prod_p0[i*PARTIAL_MUL_BW +: PARTIAL_MUL_BW] =
                PARTIAL_MUL_BW'($signed(row_in_flat[i*DATA_BW +: DATA_BW])) *
                PARTIAL_MUL_BW'($signed(vec_q[i*DATA_BW +: DATA_BW]));
        end
    end

    adder_tree_8 #(
        .IN_BW  (PARTIAL_MUL_BW),
        .OUT_BW (ACC_BW)
    ) u_tree (
        .in_flat (prod_p0),
        .sum     (acc_p0)
    );

    // Stage p1: result register, row counter, vector latch and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vec_q   <= '0;
            row_cnt <= '0;
            sum_p1  <= '0;
            idx_p1  <= '0;
            vld_p1  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (row_hs) begin
                sum_p1  <= wrap_sum(acc_p0);
                idx_p1  <= row_cnt;
                vld_p1  <= 1'b1;
                row_cnt <= row_cnt + 3'd1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) state <= WAIT_VEC;
                end
                WAIT_VEC: begin
                    if (vec_hs) begin
                        vec_q   <= vec_in_flat;
                        row_cnt <= '0;
                        state   <= ROWS;
                    end
                end
                ROWS: begin
                    if (row_hs && row_cnt == 3'(MATRIX_SIZE - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (vld_p1 && out_ready) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_sum     = sum_p1;
    assign out_row_idx = idx_p1;
    assign out_valid   = vld_p1;
    assign done        = done_q;

endmodule
